// File: rtl/sc_mux_neuron_frame.sv
// sc_mux_neuron_frame: framed stochastic neuron (XNOR multiply, LFSR MUX add, S-state stanh).
// Define SC_NEURON_ACC_EN to add the per-frame ones counter on port acc.
module sc_mux_neuron_frame #(
    parameter int K       = 3,
    parameter int S       = 8,
    parameter int FRAME_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2**K-1:0]   din,
    input  logic [2**K-1:0]   weight,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
`ifdef SC_NEURON_ACC_EN
    output logic [FRAME_W:0]  acc,
`endif
    output logic              done
);
    localparam int N  = 2**K;
    localparam int SW = $clog2(S);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [SW-1:0]       st_q, st_d;
    logic [FRAME_W-1:0]  cnt_q;
    logic [N-1:0]        p;
    logic                m, hi;
    logic                ready_q, dout_q, dv_q, busy_q, done_q;
`ifdef SC_NEURON_ACC_EN
    logic [FRAME_W:0]    acc_q;
    assign acc = acc_q;
`endif

    assign in_ready   = ready_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        p      = ~(din ^ weight);
        m      = p[lfsr_q[K-1:0]];
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        st_d   = m ? (st_q == SW'(S-1) ? st_q : st_q + 1'b1)
                   : (st_q == '0 ? st_q : st_q - 1'b1);
        hi     = st_d >= SW'(S/2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= 16'h0001;
            st_q    <= SW'(S/2);
            cnt_q   <= '0;
            ready_q <= 1'b0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SC_NEURON_ACC_EN
            acc_q   <= '0;
`endif
        end else begin
            dv_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= RUN;
                    lfsr_q  <= (seed == '0) ? 16'h0001 : seed;
                    st_q    <= SW'(S/2);
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b1;
`ifdef SC_NEURON_ACC_EN
                    acc_q   <= '0;
`endif
                end
                RUN: if (in_valid) begin
                    lfsr_q <= lfsr_d;
                    st_q   <= st_d;
                    dout_q <= hi;
                    dv_q   <= 1'b1;
`ifdef SC_NEURON_ACC_EN
                    acc_q  <= acc_q + {{FRAME_W{1'b0}}, hi};
`endif
                    // last beat: its output pulse lands in the DONE cycle
                    if (cnt_q == '1) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sc_mux_neuron_frame.sv
// tb_sc_mux_neuron_frame: randomized frames checked cycle by cycle against a behavioural model.
module tb_sc_mux_neuron_frame;
    localparam int K = 3, S = 8, FW = 4, N = 8, FL = 16;

    logic clk = 0, reset = 0, start = 0, in_valid = 0;
    logic [15:0] seed = '0;
    logic [N-1:0] din = '0, weight = '0;
    logic in_ready, dout, dout_valid, busy, done;
`ifdef SC_NEURON_ACC_EN
    logic [FW:0] acc;
`endif

    sc_mux_neuron_frame #(.K(K), .S(S), .FRAME_W(FW)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed), .in_valid(in_valid),
        .in_ready(in_ready), .din(din), .weight(weight), .dout(dout),
        .dout_valid(dout_valid), .busy(busy),
`ifdef SC_NEURON_ACC_EN
        .acc(acc),
`endif
        .done(done));

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    int m_mode = 0, m_st = S/2, m_cnt = 0, m_acc = 0;
    logic [15:0] m_lfsr = 16'h0001;
    logic m_dout = 0, m_dv = 0, m_done = 0;
    int pulses, ones, busy_cyc;
    logic dseq[$], dseq0[$];
    logic [N-1:0] din_a[FL], w_a[FL];

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // advance the model by one edge using the inputs currently driven, then compare
    task automatic cycle();
        logic [2:0] sel;
        logic mb;
        m_dv = 0;
        m_done = 0;
        if (!reset) begin
            m_mode = 0; m_st = S/2; m_lfsr = 16'h0001; m_cnt = 0; m_acc = 0; m_dout = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1; m_lfsr = (seed == 0) ? 16'h0001 : seed; m_st = S/2; m_cnt = 0; m_acc = 0;
            end
        end else if (m_mode == 1) begin
            if (in_valid) begin
                sel = m_lfsr[2:0];
                mb = ~(din[sel] ^ weight[sel]);
                m_st = mb ? ((m_st < S-1) ? m_st + 1 : m_st) : ((m_st > 0) ? m_st - 1 : 0);
                m_dout = (m_st >= S/2);
                m_dv = 1;
                m_acc += int'(m_dout);
                m_lfsr = lfsr_adv(m_lfsr);
                if (m_cnt == FL-1) begin m_mode = 2; m_done = 1; end
                else m_cnt++;
            end
        end else begin
            m_mode = 0;
        end
        @(posedge clk);
        #1;
        check("ctl{rdy,busy,done,dv,dout}", {27'd0, in_ready, busy, done, dout_valid, dout},
              {27'd0, m_mode == 1, m_mode != 0, m_done, m_dv, m_dout});
`ifdef SC_NEURON_ACC_EN
        check("acc", 32'(acc), 32'(m_acc));
`endif
        if (dout_valid === 1'b1) begin
            pulses++;
            ones += int'(dout);
            dseq.push_back(dout);
        end
        if (busy === 1'b1) busy_cyc++;
    endtask

    // kind: 0 FF/FF, 1 00/FF, 2 5A/A5, 3 5A/5A, 4 random, 5 from din_a/w_a
    task automatic frame(input logic [15:0] sd, input int kind, input bit toggle);
        int i, b;
        start = 1; seed = sd; in_valid = $urandom % 2;
        cycle();
        start = 0;
        pulses = 0; ones = 0; busy_cyc = 1; b = 0;
        dseq.delete();
        for (i = 0; i < 400 && m_mode == 1; i++) begin
            in_valid = toggle ? (i % 2 == 0) : (kind == 4 ? ($urandom % 4 != 0) : 1'b1);
            start = $urandom % 2;
            case (kind)
                0: begin din = 8'hFF; weight = 8'hFF; end
                1: begin din = 8'h00; weight = 8'hFF; end
                2: begin din = 8'h5A; weight = 8'hA5; end
                3: begin din = 8'h5A; weight = 8'h5A; end
                5: begin din = din_a[b % FL]; weight = w_a[b % FL]; end
                default: begin din = N'($urandom); weight = N'($urandom); end
            endcase
            if (in_valid) b++;
            cycle();
        end
        check("frame_budget", 32'(m_mode == 1), 0);
        start = 1; in_valid = 1;
        cycle();
        start = 0; in_valid = 0;
        cycle();
    endtask

    initial begin
        check("model_lfsr_ace1", 32'(lfsr_adv(16'hACE1)), 32'h59C3);
        check("model_lfsr_one", 32'(lfsr_adv(16'h0001)), 32'h0002);
        reset = 0;
        repeat (2) cycle();
        check("reset_busy", 32'(busy), 0);
        reset = 1;
        cycle();

        frame($urandom, 0, 0);
        check("ff_pulses", pulses, 16);
        check("ff_ones", ones, 16);
`ifdef SC_NEURON_ACC_EN
        check("ff_acc", 32'(acc), 16);
`endif
        frame($urandom, 1, 0);
        check("zero_pulses", pulses, 16);
        check("zero_ones", ones, 0);
        frame($urandom, 2, 0);
        check("xnor0_ones", ones, 0);
        frame($urandom, 3, 0);
        check("xnor1_ones", ones, 16);
        frame(16'hACE1, 4, 1);
        check("toggle_pulses", pulses, 16);
        check("toggle_busy_cycles", busy_cyc, 32);

        for (int i = 0; i < FL; i++) begin din_a[i] = N'($urandom); w_a[i] = N'($urandom); end
        frame(16'h0000, 5, 0);
        dseq0 = dseq;
        frame(16'h0001, 5, 0);
        check("seed0_len", dseq.size(), dseq0.size());
        for (int i = 0; i < dseq.size() && i < dseq0.size(); i++)
            check("seed0_vs_seed1", 32'(dseq0[i]), 32'(dseq[i]));

        start = 1; seed = $urandom; cycle(); start = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1; din = N'($urandom); weight = N'($urandom); cycle();
        end
        reset = 0; in_valid = 1;
        cycle();
        check("abort_done", 32'(done), 0);
        check("abort_busy", 32'(busy), 0);
        reset = 1; in_valid = 0;
        repeat (2) cycle();
        check("abort_no_done", 32'(done), 0);
        frame($urandom, 1, 0);
        check("fresh_pulses", pulses, 16);
        frame($urandom, 0, 0);
        check("fresh_ff_ones", ones, 16);

        for (int f = 0; f < 20; f++) frame($urandom, 4, $urandom % 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
